// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared state type, defaults and sizing helpers for the config chain loader
package config_pkg;

    localparam int CFG_WORD_W    = 8;
    localparam int CFG_CHAIN_LEN = 14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } cfg_ctrl_state_t;

    // Host words needed to cover the chain; the last word may be partly unused.
    function automatic int cfg_num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int cfg_idx_w(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// rtl/cfg_serializer.sv - word shift register with one-word holding buffer, emits one bit per advance
module cfg_serializer
    import config_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              hold_wr_i,
    input  logic              advance_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              bit_o,
    output logic              word_boundary_o,
    output logic              hold_full_o
);

    localparam int               IDX_W    = cfg_idx_w(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              full_q, full_d;

    assign word_boundary_o = advance_i && (idx_q == LAST_IDX);
    assign bit_o           = shift_q[idx_q];
    assign hold_full_o     = full_q;

    always_comb begin
        shift_d = shift_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        full_d  = full_q;
        if (clear_i) begin
            shift_d = '0;
            hold_d  = '0;
            idx_d   = '0;
            full_d  = 1'b0;
        end else if (load_i) begin
            shift_d = data_i;
            idx_d   = '0;
            full_d  = 1'b0;
        end else if (advance_i) begin
            if (word_boundary_o) begin
                idx_d = '0;
                // A word arriving on the boundary cycle bypasses the holding register.
                if (hold_wr_i) begin
                    shift_d = data_i;
                end else if (full_q) begin
                    shift_d = hold_q;
                    full_d  = 1'b0;
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
                if (hold_wr_i) begin
                    hold_d = data_i;
                    full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: rtl/config_chain_ctrl.sv
// rtl/config_chain_ctrl.sv - loads host words serially into the soft or hard config chain and commits
module config_chain_ctrl
    import config_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W,
    parameter int CHAIN_LEN = CFG_CHAIN_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hard,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              shift_in_soft,
    output logic              shift_in_hard,
    output logic              set_soft,
    output logic              set_hard,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int               NW       = cfg_num_words(CHAIN_LEN, WORD_W);
    localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam int               WC_W     = $clog2(NW + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0]  NW_CNT   = WC_W'(NW);

    cfg_ctrl_state_t   state_q, state_d;
    logic              hard_q, hard_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;

    logic in_shift;
    logic xfer;
    logic last_bit;
    logic underrun;
    logic ser_bit;
    logic word_boundary;
    logic hold_full;
    logic ser_clear;

    assign in_shift   = (state_q == ST_SHIFT);
    assign data_ready = (state_q == ST_FILL) ||
                        (in_shift && !hold_full && (word_cnt_q < NW_CNT));
    assign xfer       = data_valid && data_ready;
    assign last_bit   = in_shift && (bit_cnt_q == LAST_BIT);
    // The chain cannot pause, so an empty buffer at a word edge aborts the load.
    assign underrun   = word_boundary && !last_bit && !hold_full && !xfer;
    assign ser_clear  = ((state_q == ST_IDLE) && start) || underrun;

    cfg_serializer #(
        .WORD_W(WORD_W)
    ) u_serializer (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_i         (ser_clear),
        .load_i          ((state_q == ST_FILL) && xfer),
        .hold_wr_i       (in_shift && xfer),
        .advance_i       (in_shift),
        .data_i          (data_in),
        .bit_o           (ser_bit),
        .word_boundary_o (word_boundary),
        .hold_full_o     (hold_full)
    );

    always_comb begin
        state_d    = state_q;
        hard_d     = hard_q;
        error_d    = error_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hard_d     = hard;
                    error_d    = 1'b0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (xfer) begin
                    bit_cnt_d  = '0;
                    word_cnt_d = WC_W'(1);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (xfer) begin
                    word_cnt_d = word_cnt_q + WC_W'(1);
                end
                if (last_bit) begin
                    state_d = ST_COMMIT;
                end else if (underrun) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hard_q     <= 1'b0;
            error_q    <= 1'b0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hard_q     <= hard_d;
            error_q    <= error_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign shift_in_soft = in_shift && !hard_q && ser_bit;
    assign shift_in_hard = in_shift && hard_q && ser_bit;
    assign set_soft      = (state_q == ST_COMMIT) && !hard_q;
    assign set_hard      = (state_q == ST_COMMIT) && hard_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign error         = error_q;

endmodule

// File: tb/tb_config_chain_ctrl.sv
// tb/tb_config_chain_ctrl.sv - scoreboard bench for config_chain_ctrl (14-bit and 16-bit chains)
module tb_config_chain_ctrl;

    localparam logic [1:0] K_COMMIT = 2'd0;
    localparam logic [1:0] K_UNDER  = 2'd1;
    localparam logic [1:0] K_ABORT  = 2'd2;
    localparam logic [1:0] K_NONE   = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        hard;
        logic [15:0] bits;
        logic [7:0]  nxfer;
        logic [7:0]  nshift;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start_w [2];
    logic       hard_w  [2];
    logic [7:0] din_w   [2];
    logic       valid_w [2];
    logic       ready_w [2];
    logic       soft_w  [2];
    logic       hline_w [2];
    logic       sets_w  [2];
    logic       seth_w  [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       err_w   [2];

    int   checks;
    int   failures;
    exp_t sb0 [$];
    exp_t sb1 [$];

    config_chain_ctrl #(.WORD_W(8), .CHAIN_LEN(14)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .hard(hard_w[0]),
        .data_in(din_w[0]), .data_valid(valid_w[0]), .data_ready(ready_w[0]),
        .shift_in_soft(soft_w[0]), .shift_in_hard(hline_w[0]),
        .set_soft(sets_w[0]), .set_hard(seth_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0])
    );

    config_chain_ctrl #(.WORD_W(8), .CHAIN_LEN(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .hard(hard_w[1]),
        .data_in(din_w[1]), .data_valid(valid_w[1]), .data_ready(ready_w[1]),
        .shift_in_soft(soft_w[1]), .shift_in_hard(hline_w[1]),
        .set_soft(sets_w[1]), .set_hard(seth_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    function automatic logic [7:0] outs(input int k);
        return {ready_w[k], soft_w[k], hline_w[k], sets_w[k], seth_w[k],
                busy_w[k], done_w[k], err_w[k]};
    endfunction

    function automatic exp_t mk(input logic [1:0] kind, input logic h, input logic [15:0] bits,
                                input int nx, input int ns);
        exp_t e;
        e.kind   = kind;
        e.hard   = h;
        e.bits   = bits;
        e.nxfer  = 8'(nx);
        e.nshift = 8'(ns);
        return e;
    endfunction

    function automatic exp_t pop_exp(input int k);
        exp_t e;
        e      = '0;
        e.kind = K_NONE;
        if (k == 0) begin
            if (sb0.size() > 0) e = sb0.pop_front();
        end else begin
            if (sb1.size() > 0) e = sb1.pop_front();
        end
        return e;
    endfunction

    always @(negedge rst_n) begin
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("async_reset_outputs[%0d]", k), outs(k), 0);
    end

    for (genvar gk = 0; gk < 2; gk++) begin : g_mon
        localparam int LEN = (gk == 0) ? 14 : 16;
        int          ph;
        int          cnt;
        int          nx;
        logic [15:0] cs;
        logic [15:0] chh;
        exp_t        e;

        initial begin
            ph  = 0;
            cnt = 0;
            nx  = 0;
            cs  = '0;
            chh = '0;
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                chk($sformatf("reset_outputs[%0d]", gk), outs(gk), 0);
                if (ph != 0) begin
                    e = pop_exp(gk);
                    chk($sformatf("abort_kind[%0d]", gk), e.kind, K_ABORT);
                end
                ph = 0;
            end else begin
                if (ph == 0) begin
                    if (busy_w[gk]) begin
                        chk($sformatf("error_cleared_on_start[%0d]", gk), err_w[gk], 0);
                        ph  = 1;
                        nx  = 0;
                        cnt = 0;
                        cs  = '0;
                        chh = '0;
                    end else if (valid_w[gk]) begin
                        chk($sformatf("idle_ready[%0d]", gk), ready_w[gk], 0);
                    end
                end
                if (ph == 1) begin
                    if (valid_w[gk] && ready_w[gk]) begin
                        nx = 1;
                        ph = 2;
                    end
                end else if (ph == 2) begin
                    if (valid_w[gk] && ready_w[gk]) nx++;
                    if (!busy_w[gk]) begin
                        e = pop_exp(gk);
                        chk($sformatf("end_kind_underrun[%0d]", gk), e.kind, K_UNDER);
                        chk($sformatf("underrun_error[%0d]", gk), err_w[gk], 1);
                        chk($sformatf("underrun_shift_cycles[%0d]", gk), cnt, e.nshift);
                        chk($sformatf("underrun_bits[%0d]", gk), e.hard ? chh : cs, e.bits);
                        chk($sformatf("underrun_xfers[%0d]", gk), nx, e.nxfer);
                        ph = 0;
                    end else if (sets_w[gk] || seth_w[gk]) begin
                        e = pop_exp(gk);
                        chk($sformatf("end_kind_commit[%0d]", gk), e.kind, K_COMMIT);
                        chk($sformatf("commit_cycle[%0d]", gk), cnt, LEN);
                        chk($sformatf("chain_bits[%0d]", gk), e.hard ? chh : cs, e.bits);
                        chk($sformatf("unselected_line[%0d]", gk), e.hard ? cs : chh, 0);
                        chk($sformatf("set_pulse_sel[%0d]", gk), {seth_w[gk], sets_w[gk]},
                            {e.hard, ~e.hard});
                        chk($sformatf("commit_lines_low[%0d]", gk), {soft_w[gk], hline_w[gk]}, 0);
                        chk($sformatf("xfer_count[%0d]", gk), nx, e.nxfer);
                        chk($sformatf("commit_no_error[%0d]", gk), err_w[gk], 0);
                        ph = 3;
                    end else begin
                        if (cnt < 16) begin
                            cs[cnt]  = soft_w[gk];
                            chh[cnt] = hline_w[gk];
                        end
                        cnt++;
                    end
                end else if (ph == 3) begin
                    chk($sformatf("done_pulse[%0d]", gk), done_w[gk], 1);
                    chk($sformatf("set_one_cycle[%0d]", gk), {sets_w[gk], seth_w[gk]}, 0);
                    ph = 4;
                end else if (ph == 4) begin
                    chk($sformatf("idle_after_done[%0d]", gk), {busy_w[gk], done_w[gk]}, 0);
                    ph = 0;
                end
            end
        end
    end

    task automatic run_load(input int k, input logic h, input logic [7:0] w0, input logic [7:0] w1,
                            input int nsend, input bit hold_v, input bit poke, input int rst_cyc);
        bit acc;
        bit fin;
        @(posedge clk); #1;
        start_w[k] = 1'b1;
        hard_w[k]  = h;
        din_w[k]   = w0;
        valid_w[k] = 1'b1;
        @(posedge clk); #1;
        start_w[k] = 1'b0;
        hard_w[k]  = ~h;
        for (int i = 0; i < nsend; i++) begin
            din_w[k] = (i == 0) ? w0 : w1;
            acc = 1'b0;
            for (int c = 0; c < 20 && !acc; c++) begin
                @(negedge clk);
                if (ready_w[k]) acc = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
            if (!acc) timeout_fail("word_transfer");
            @(posedge clk); #1;
        end
        din_w[k]   = 8'hEE;
        valid_w[k] = hold_v;
        if (rst_cyc > 0) begin
            repeat (rst_cyc - 1) @(negedge clk);
            #1 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            valid_w[k] = 1'b0;
        end else begin
            fin = 1'b0;
            for (int c = 0; c < 60 && !fin; c++) begin
                @(negedge clk);
                if (!busy_w[k]) fin = 1'b1;
                else if (poke) start_w[k] = (c == 3) || sets_w[k] || seth_w[k];
            end
            start_w[k] = 1'b0;
            valid_w[k] = 1'b0;
            if (!fin) timeout_fail("load_completion");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_w[k] = 1'b0;
            hard_w[k]  = 1'b0;
            din_w[k]   = 8'h00;
            valid_w[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Word offered while idle must stay unconsumed and become the first word of the load.
        valid_w[0] = 1'b1;
        din_w[0]   = 8'hA5;
        repeat (3) @(posedge clk);
        #1;

        // 0xA5 then 0x3C LSB-first: 1,0,1,0,0,1,0,1,0,0,1,1,1,1 -> bit k of 14'h3CA5.
        sb0.push_back(mk(K_COMMIT, 1'b0, 16'h3CA5, 2, 0));
        run_load(0, 1'b0, 8'hA5, 8'h3C, 2, 1'b0, 1'b0, 0);

        sb0.push_back(mk(K_COMMIT, 1'b1, 16'h3CA5, 2, 0));
        run_load(0, 1'b1, 8'hA5, 8'h3C, 2, 1'b0, 1'b1, 0);

        sb0.push_back(mk(K_UNDER, 1'b0, 16'h00A5, 1, 8));
        run_load(0, 1'b0, 8'hA5, 8'h3C, 1, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;

        sb0.push_back(mk(K_COMMIT, 1'b0, 16'h3CA5, 2, 0));
        run_load(0, 1'b0, 8'hA5, 8'h3C, 2, 1'b0, 1'b0, 0);

        sb0.push_back(mk(K_ABORT, 1'b0, 16'h0000, 0, 0));
        run_load(0, 1'b0, 8'hA5, 8'h3C, 2, 1'b0, 1'b0, 5);

        sb0.push_back(mk(K_COMMIT, 1'b1, 16'h3CA5, 2, 0));
        run_load(0, 1'b1, 8'hA5, 8'h3C, 2, 1'b0, 1'b0, 0);

        // 16-bit chain: 0xFF then 0x00 gives eight ones then eight zeros.
        sb1.push_back(mk(K_COMMIT, 1'b0, 16'h00FF, 2, 0));
        run_load(1, 1'b0, 8'hFF, 8'h00, 2, 1'b1, 1'b0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb0.size() + sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
